// File: rtl/micro_tlb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tlb_pkg
//  Description : Shared types for the micro TLB: virtual address, main-TLB
//                result, cached entry and refill FSM state.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_tlb_pkg;

    localparam int VPN_W = 20;
    localparam int PFN_W = 20;

    typedef logic [31:0] virt_t;

    // Translation returned by the main TLB and cached per entry.
    typedef struct packed {
        logic             miss;
        logic [PFN_W-1:0] pfn;
        logic [2:0]       cattr;
        logic             dirty;
    } tlb_result_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        tlb_result_t      result;
    } micro_tlb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } tlb_state_e;

    // Virtual page number of a 4 KiB page.
    function automatic logic [VPN_W-1:0] vpn_of(input virt_t va);
        return va[31:12];
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_tlb_match.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tlb_match
//  Description : Fully associative VPN compare across all entries with a
//                result mux; the lowest-numbered matching entry wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_tlb_match
    import micro_tlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  micro_tlb_entry_t       entries_i [ENTRIES],
    input  logic [VPN_W-1:0]       vpn_i,
    output logic                   hit_o,
    output tlb_result_t            result_o
);

    logic w_found;

    // Scan every entry; first valid match supplies the result.
    always_comb begin
        w_found  = 1'b0;
        result_o = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!w_found && entries_i[e].valid && (entries_i[e].vpn == vpn_i)) begin
                w_found  = 1'b1;
                result_o = entries_i[e].result;
            end
        end
        hit_o = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/micro_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tlb
//  Description : Small fully associative translation cache in front of the
//                main TLB. Multi-port combinational lookup, single refill
//                engine with FIFO (round-robin) replacement, invalidation on
//                flush or ASID change. Optional hit/miss counters are built
//                when MICRO_TLB_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_tlb
    import micro_tlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PORTS   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              asid,
    input  logic                    flush,
    input  logic [PORTS-1:0]        lookup_valid,
    input  virt_t [PORTS-1:0]       lookup_vaddr,
    output logic [PORTS-1:0]        lookup_hit,
    output tlb_result_t [PORTS-1:0] lookup_result,
    output logic                    refill_req,
    output virt_t                   refill_vaddr,
    input  logic                    refill_ack,
    input  tlb_result_t             refill_result,
    output logic                    refill_done,
    output logic                    refill_miss,
    output logic                    busy
`ifdef MICRO_TLB_PERF_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    micro_tlb_entry_t   entries_q [ENTRIES];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    tlb_state_e         state_q, state_d;
    virt_t              vaddr_q, vaddr_d;
    logic               stale_q, stale_d;
    logic [7:0]         asid_q;

    logic               w_inval;
    logic               w_install;
    logic               w_any_miss;
    virt_t              w_miss_vaddr;
    micro_tlb_entry_t   w_new_entry;
    logic [PORTS-1:0]   w_match_hit;
    tlb_result_t        w_match_res [PORTS];

    // An ASID switch is treated exactly like a flush.
    assign w_inval = flush | (asid != asid_q);

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [VPN_W-1:0] w_vpn;
        assign w_vpn = vpn_of(lookup_vaddr[p]);

        micro_tlb_match #(
            .ENTRIES (ENTRIES)
        ) u_match (
            .entries_i (entries_q),
            .vpn_i     (w_vpn),
            .hit_o     (w_match_hit[p]),
            .result_o  (w_match_res[p])
        );

        assign lookup_hit[p]    = lookup_valid[p] & w_match_hit[p];
        assign lookup_result[p] = lookup_hit[p] ? w_match_res[p] : '0;
    end

    // Pick the lowest-numbered port that is active and missing.
    always_comb begin
        w_any_miss   = 1'b0;
        w_miss_vaddr = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (lookup_valid[p] && !w_match_hit[p]) begin
                w_any_miss   = 1'b1;
                w_miss_vaddr = lookup_vaddr[p];
            end
        end
    end

    // Refill FSM next-state and outputs. A refill overlapped by an
    // invalidation (earlier in REQ, or on the ack cycle itself) installs nothing.
    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        stale_d     = stale_q;
        w_install   = 1'b0;
        refill_req  = 1'b0;
        refill_done = 1'b0;
        refill_miss = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_any_miss) begin
                    vaddr_d = w_miss_vaddr;
                    stale_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                refill_req = 1'b1;
                if (w_inval) begin
                    stale_d = 1'b1;
                end
                if (refill_ack) begin
                    refill_done = 1'b1;
                    refill_miss = refill_result.miss;
                    w_install   = !refill_result.miss && !stale_q && !w_inval;
                    stale_d     = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Victim pointer advances only when an entry is actually written.
    always_comb begin
        ptr_d = ptr_q;
        if (w_install) begin
            ptr_d = (ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Entry image written on a successful refill.
    always_comb begin
        w_new_entry        = '0;
        w_new_entry.valid  = 1'b1;
        w_new_entry.vpn    = vpn_of(vaddr_q);
        w_new_entry.result = refill_result;
    end

    assign busy         = (state_q != ST_IDLE);
    assign refill_vaddr = vaddr_q;

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            vaddr_q <= '0;
            stale_q <= 1'b0;
            asid_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vaddr_q <= vaddr_d;
            stale_q <= stale_d;
            asid_q  <= asid;
        end
    end

    // Entry storage: invalidate-all, or install at the victim pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_inval) begin
                    entries_q[e].valid <= 1'b0;
                end
            end
            if (w_install) begin
                entries_q[ptr_q] <= w_new_entry;
            end
        end
    end

`ifdef MICRO_TLB_PERF_EN
    logic [31:0] hit_count_q, miss_count_q;
    logic [31:0] w_hit_inc, w_miss_inc;

    // Number of ports hitting / missing this cycle.
    always_comb begin
        w_hit_inc  = '0;
        w_miss_inc = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (lookup_valid[p] && w_match_hit[p]) begin
                w_hit_inc = w_hit_inc + 32'd1;
            end
            if (lookup_valid[p] && !w_match_hit[p]) begin
                w_miss_inc = w_miss_inc + 32'd1;
            end
        end
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_q + w_hit_inc;
            miss_count_q <= miss_count_q + w_miss_inc;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_micro_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_tlb
//  Description : Self-checking bench for micro_tlb: directed scenarios then
//                randomized lookups/refills against a reference cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_tlb;
    import micro_tlb_pkg::*;

    localparam int ENTRIES = 4;
    localparam int PORTS   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [7:0]              asid;
    logic                    flush;
    logic [PORTS-1:0]        lookup_valid;
    virt_t [PORTS-1:0]       lookup_vaddr;
    logic [PORTS-1:0]        lookup_hit;
    tlb_result_t [PORTS-1:0] lookup_result;
    logic                    refill_req;
    virt_t                   refill_vaddr;
    logic                    refill_ack;
    tlb_result_t             refill_result;
    logic                    refill_done;
    logic                    refill_miss;
    logic                    busy;
`ifdef MICRO_TLB_PERF_EN
    logic [31:0]             hit_count;
    logic [31:0]             miss_count;
`endif

    micro_tlb #(
        .ENTRIES (ENTRIES),
        .PORTS   (PORTS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .asid          (asid),
        .flush         (flush),
        .lookup_valid  (lookup_valid),
        .lookup_vaddr  (lookup_vaddr),
        .lookup_hit    (lookup_hit),
        .lookup_result (lookup_result),
        .refill_req    (refill_req),
        .refill_vaddr  (refill_vaddr),
        .refill_ack    (refill_ack),
        .refill_result (refill_result),
        .refill_done   (refill_done),
        .refill_miss   (refill_miss),
        .busy          (busy)
`ifdef MICRO_TLB_PERF_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference cache: list of pages with FIFO replacement.
    logic        m_valid [ENTRIES];
    logic [19:0] m_vpn   [ENTRIES];
    tlb_result_t m_res   [ENTRIES];
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_flush();
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        m_ptr = 0;
    endtask

    task automatic model_install(input logic [19:0] vpn, input tlb_result_t res);
        m_valid[m_ptr] = 1'b1;
        m_vpn[m_ptr]   = vpn;
        m_res[m_ptr]   = res;
        m_ptr          = (m_ptr + 1) % ENTRIES;
    endtask

    function automatic void model_hit(input virt_t va, output logic h, output tlb_result_t r);
        h = 1'b0;
        r = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!h && m_valid[e] && (m_vpn[e] == va[31:12])) begin
                h = 1'b1;
                r = m_res[e];
            end
        end
    endfunction

    task automatic check_ports();
        logic        mh;
        tlb_result_t mr;
        for (int p = 0; p < PORTS; p++) begin
            model_hit(lookup_vaddr[p], mh, mr);
            mh = mh & lookup_valid[p];
            check($sformatf("hit%0d", p), 64'(lookup_hit[p]), 64'(mh));
            check($sformatf("res%0d", p), 64'(lookup_result[p]), mh ? 64'(mr) : 64'd0);
        end
    endtask

    // One lookup; if the model predicts a miss, run the refill handshake.
    task automatic access(input logic [1:0] v, input virt_t a0, input virt_t a1,
                          input int wait_n, input logic miss_bit, input logic [19:0] pfn,
                          input logic ack_flush, input logic mid_flush);
        virt_t       exp_va;
        logic        any;
        logic        stale;
        logic        mh;
        tlb_result_t mr;
        tlb_result_t res;
        lookup_valid    = v;
        lookup_vaddr[0] = a0;
        lookup_vaddr[1] = a1;
        refill_ack      = 1'b0;
        flush           = 1'b0;
        #1;
        check("busy_idle", 64'(busy), 64'd0);
        check_ports();
        any    = 1'b0;
        exp_va = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            model_hit(lookup_vaddr[p], mh, mr);
            if (v[p] && !mh) begin
                any    = 1'b1;
                exp_va = lookup_vaddr[p];
            end
        end
        if (!any) begin
            lookup_valid = '0;
            tick();
        end else begin
            tick();
            stale = 1'b0;
            for (int i = 0; i < wait_n; i++) begin
                #1;
                check("req_held", 64'(refill_req), 64'd1);
                check("req_vaddr", 64'(refill_vaddr), 64'(exp_va));
                check("busy_req", 64'(busy), 64'd1);
                check("done_wait", 64'(refill_done), 64'd0);
                check_ports();
                if (mid_flush && i == 0) begin
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                    model_flush();
                    stale = 1'b1;
                end else begin
                    tick();
                end
            end
            res.miss      = miss_bit;
            res.pfn       = pfn;
            res.cattr     = pfn[2:0];
            res.dirty     = pfn[3];
            refill_ack    = 1'b1;
            refill_result = res;
            flush         = ack_flush;
            #1;
            check("req_at_ack", 64'(refill_req), 64'd1);
            check("vaddr_at_ack", 64'(refill_vaddr), 64'(exp_va));
            check("done", 64'(refill_done), 64'd1);
            check("refill_miss", 64'(refill_miss), 64'(miss_bit));
            if (ack_flush) model_flush();
            else if (!miss_bit && !stale) model_install(exp_va[31:12], res);
            tick();
            refill_ack    = 1'b0;
            flush         = 1'b0;
            refill_result = '0;
            #1;
            check("done_pulse", 64'(refill_done), 64'd0);
            check("busy_after", 64'(busy), 64'd0);
            check_ports();
            lookup_valid = '0;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pg0, pg1;
        logic [31:0] base_hit, base_miss;
        rst           = 1'b1;
        asid          = 8'h00;
        flush         = 1'b0;
        lookup_valid  = '0;
        lookup_vaddr  = '0;
        refill_ack    = 1'b0;
        refill_result = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        check("rst_req", 64'(refill_req), 64'd0);
        check("rst_done", 64'(refill_done), 64'd0);
        check("rst_miss", 64'(refill_miss), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_vaddr", 64'(refill_vaddr), 64'd0);
        lookup_valid    = 2'b11;
        lookup_vaddr[0] = 32'h0040_1000;
        lookup_vaddr[1] = 32'h0000_0000;
        #1;
        check("rst_hit", 64'(lookup_hit), 64'd0);
        lookup_valid = '0;
        rst          = 1'b0;
        tick();

        // First miss, refill after a 3-cycle ack wait, then hit
        access(2'b01, 32'h0040_1000, 32'h0, 3, 1'b0, 20'h12345, 1'b0, 1'b0);
        lookup_valid    = 2'b01;
        lookup_vaddr[0] = 32'h0040_1ABC;
        #1;
        check("first_hit", 64'(lookup_hit[0]), 64'd1);
        check("first_pfn", 64'(lookup_result[0].pfn), 64'h12345);
        lookup_valid = '0;
        tick();

        // Five distinct pages: the fifth evicts the first
        for (int k = 2; k <= 5; k++) begin
            access(2'b01, {20'h00400 + 20'(k), 12'h0}, 32'h0, 1, 1'b0, 20'hA0000 + 20'(k), 1'b0, 1'b0);
        end
        lookup_valid    = 2'b01;
        lookup_vaddr[0] = 32'h0040_1000;
        #1;
        check("evicted", 64'(lookup_hit[0]), 64'd0);
        lookup_valid = '0;
        tick();

        // Both ports miss: port 0 refilled first, then port 1
        access(2'b11, 32'h0040_6000, 32'h0040_7000, 2, 1'b0, 20'h00066, 1'b0, 1'b0);
        access(2'b11, 32'h0040_6000, 32'h0040_7000, 0, 1'b0, 20'h00077, 1'b0, 1'b0);

        // Main-TLB miss installs nothing; following refill lands at the same slot
        access(2'b01, 32'h0040_8000, 32'h0, 1, 1'b1, 20'h0, 1'b0, 1'b0);
        access(2'b11, 32'h0040_8000, 32'h0040_6000, 1, 1'b0, 20'h00088, 1'b0, 1'b0);

        // Flush coincident with ack: nothing installed, everything misses
        access(2'b11, 32'h0040_9000, 32'h0040_7000, 2, 1'b0, 20'h00099, 1'b1, 1'b0);
        lookup_valid    = 2'b11;
        lookup_vaddr[0] = 32'h0040_6000;
        lookup_vaddr[1] = 32'h0040_8000;
        #1;
        check("flush_ack_hit", 64'(lookup_hit), 64'd0);
        lookup_valid = '0;
        tick();

        // Flush in the middle of REQ makes the refill stale
        access(2'b01, 32'h0040_A000, 32'h0, 3, 1'b0, 20'h000AA, 1'b0, 1'b1);

        // ASID change invalidates
        access(2'b01, 32'h0040_B000, 32'h0, 0, 1'b0, 20'h000BB, 1'b0, 1'b0);
        lookup_valid    = 2'b01;
        lookup_vaddr[0] = 32'h0040_B000;
        asid            = 8'h05;
        #1;
        check("asid_pre", 64'(lookup_hit[0]), 64'd1);
        lookup_valid = '0;
        tick();
        model_flush();
        lookup_valid = 2'b01;
        #1;
        check("asid_post", 64'(lookup_hit[0]), 64'd0);
        lookup_valid = '0;
        tick();

        // Reset during REQ abandons the refill
        lookup_valid    = 2'b01;
        lookup_vaddr[0] = 32'h0040_C000;
        tick();
        check("rreq_req", 64'(refill_req), 64'd1);
        rst          = 1'b1;
        lookup_valid = '0;
        tick();
        rst                = 1'b0;
        refill_ack         = 1'b1;
        refill_result      = '0;
        refill_result.pfn  = 20'h000CC;
        #1;
        check("rreq_done", 64'(refill_done), 64'd0);
        check("rreq_busy", 64'(busy), 64'd0);
        check("rreq_req2", 64'(refill_req), 64'd0);
        tick();
        refill_ack = 1'b0;
        model_reset();
        lookup_valid = 2'b01;
        #1;
        check("rreq_hit", 64'(lookup_hit[0]), 64'd0);
        lookup_valid = '0;
        tick();
        tick();

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            logic [1:0] v;
            virt_t      a0, a1;
            pg0 = 20'h00400 + 20'($urandom_range(0, 5));
            pg1 = 20'h00400 + 20'($urandom_range(0, 5));
            a0  = {pg0, 12'($urandom)};
            a1  = {pg1, 12'($urandom)};
            v   = 2'($urandom_range(1, 3));
            access(v, a0, a1, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   20'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

`ifdef MICRO_TLB_PERF_EN
        // Ten cycles of two-port hits
        access(2'b01, 32'h0050_0000, 32'h0, 0, 1'b0, 20'h00500, 1'b0, 1'b0);
        access(2'b01, 32'h0050_1000, 32'h0, 0, 1'b0, 20'h00501, 1'b0, 1'b0);
        base_hit        = hit_count;
        base_miss       = miss_count;
        lookup_valid    = 2'b11;
        lookup_vaddr[0] = 32'h0050_0010;
        lookup_vaddr[1] = 32'h0050_1020;
        repeat (10) tick();
        lookup_valid = '0;
        #1;
        check("perf_hits", 64'(hit_count - base_hit), 64'd20);
        check("perf_miss", 64'(miss_count - base_miss), 64'd0);
`else
        pg0       = '0;
        pg1       = '0;
        base_hit  = '0;
        base_miss = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/micro_tlb.md
MICRO_TLB -- requirements
Module: micro_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, meaning the number of cached translations (power of two, 2..16).
REQ-002 SHALL have parameter PORTS, default 2, meaning the number of parallel lookup ports (1..4).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port asid, input, 8, the current address-space ID.
REQ-006 SHALL have port flush, input, 1, the invalidate-all request (TLBWI/TLBWR commit).
REQ-007 SHALL have port lookup_valid, input, PORTS, marking lookups as active.
REQ-008 SHALL have port lookup_vaddr, input, PORTS x virt_t, the addresses to translate.
REQ-009 SHALL have port lookup_hit, output, PORTS, indicating a translation hit.
REQ-010 SHALL have port lookup_result, output, PORTS x tlb_result_t, the cached translation.
REQ-011 SHALL have port refill_req, output, 1, requesting a main-TLB lookup.
REQ-012 SHALL have port refill_vaddr, output, virt_t, the address being refilled.
REQ-013 SHALL have port refill_ack, input, 1, signalling that the main TLB has answered.
REQ-014 SHALL have port refill_result, input, tlb_result_t, the main-TLB answer.
REQ-015 SHALL have port refill_done, output, 1, a one-cycle pulse marking refill completion.
REQ-016 SHALL have port refill_miss, output, 1, valid with refill_done and high when the main TLB missed.
REQ-017 SHALL have port busy, output, 1, high while the FSM is not in IDLE.

Function
REQ-018 SHALL store per entry: valid, vpn = vaddr[31:12], and the result.
REQ-019 SHALL compute lookup_hit[p] combinationally as lookup_valid[p] and any entry with a valid, matching vpn; lookup_result[p] SHALL be that entry's result, or zero on a miss.
REQ-020 SHALL implement an FSM with states IDLE and REQ.
REQ-021 In IDLE, if any port has valid && !hit, the FSM SHALL latch the lowest-numbered such port's vaddr and move to REQ on the next cycle.
REQ-022 In REQ, refill_req SHALL be held high and refill_vaddr held stable until refill_ack is sampled high.
REQ-023 On ack with refill_result.miss == 0, the FSM SHALL write the entry at the victim pointer (valid=1) and increment the pointer modulo ENTRIES, wrapping from ENTRIES-1 to 0.
REQ-024 On ack with refill_result.miss == 1, the FSM SHALL install nothing and leave the pointer unchanged.
REQ-025 On every ack, the block SHALL assert refill_done for one cycle with refill_miss = refill_result.miss, and the FSM SHALL return to IDLE.
REQ-026 A hit on a refilled address SHALL occur on the cycle after ack at the earliest (latency 2 cycles from miss to REQ, plus the ack wait, plus 1).
REQ-027 flush, or asid differing from its registered value, SHALL clear all valid bits on the next edge; the pointer SHALL NOT be cleared.
REQ-028 A flush or ASID change while in REQ SHALL mark the refill stale; on ack, a stale refill SHALL install nothing but still pulse refill_done.
REQ-029 When flush and refill_ack occur in the same cycle, flush SHALL win and no entry SHALL be installed.
REQ-030 Hits on other ports SHALL continue to be served while the FSM is in REQ.

Reset
REQ-031 On reset, all valid bits, the pointer, and the stale flag SHALL be 0; the FSM SHALL be IDLE; the registered asid SHALL be 0.
REQ-032 After reset, refill_req, refill_done, refill_miss, busy and lookup_hit SHALL be 0, and refill_vaddr SHALL be 0.
REQ-033 A reset while in REQ SHALL abandon the refill; a subsequent ack SHALL be ignored.

Configuration
REQ-034 When MICRO_TLB_PERF_EN is defined, the block SHALL add 32-bit outputs hit_count and miss_count.
REQ-035 Under MICRO_TLB_PERF_EN, each counter SHALL increment once per cycle per port with valid && hit (hit_count) or valid && !hit (miss_count), wrapping modulo 2^32, and SHALL reset to 0.
REQ-036 Without MICRO_TLB_PERF_EN, the block SHALL have no counter ports or logic.

Structure
REQ-037 The shared package SHALL hold micro_tlb_entry_t {valid, vpn[19:0], tlb_result_t result} and the FSM state enum.
REQ-038 The block SHALL contain one sub-module, micro_tlb_match, instantiated per port, doing the ENTRIES-way vpn compare and result mux.

Verification
REQ-039 After reset, a port-0 lookup of 0x00401000 SHALL give hit=0; refill_req SHALL rise the next cycle; an ack 3 cycles later with a valid result SHALL give refill_done and then hit=1 with matching pfn.
REQ-040 Filling 5 distinct pages with ENTRIES=4 SHALL cause the 5th to overwrite entry 0, so the first page then misses.
REQ-041 Both ports missing different pages in the same cycle SHALL refill port 0's address first, then port 1's.
REQ-042 Asserting flush in the same cycle as refill_ack SHALL install nothing, pulse refill_done, and make all lookups miss afterwards.
REQ-043 An ack with refill_result.miss=1 SHALL pulse refill_done with refill_miss=1 and leave the entry count and pointer unchanged.
REQ-044 Under MICRO_TLB_PERF_EN, 10 cycles of 2-port hits SHALL leave hit_count at 20 and miss_count at 0.
